keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Avalon-MM slave that autonomously scans a 5-column keypad matrix, debounces every key and queues press/release events in a FIFO for the Nios II CPU. It replaces software polling of the 5-bit key-drive PIO. It sits between the Qsys interconnect and the board keypad pins: it drives the column lines itself and consumes the row lines.

## Interface
- ROWS, 4, number of row inputs (1-8)
- SETTLE_CYCLES, 500, clocks a column is driven before its rows are sampled (≥1)
- DEBOUNCE_SCANS, 4, consecutive differing samples needed to accept a key change (1-15)
- FIFO_DEPTH, 8, event FIFO entries (power of 2, 2-64)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational, read latency 0
- col_out  out  5  column drive, active-low, one-cold while scanning
- row_in  in  ROWS  row sense, active-low, asynchronous, externally pulled up
- irq  out  1  interrupt request, active-high

## Operation
- Register map:
  - 0 EVENT (RO): bit31 valid, bit8 press=1/release=0, bits6:4 row, bits2:0 col, others 0.
  - 1 STATUS: bits6:0 FIFO count, bit16 overflow (sticky; write 1 clears), bit24 scan-enable mirror.
  - 2 CONTROL (RW): bit0 enable (reset 0); bit1 flush (write 1 empties FIFO, self-clearing, reads 0).
  - 3 IRQ_MASK: see Configuration.
- A read of EVENT pops the FIFO head when it is non-empty: every cycle with chipselect & ~read_n & address==0. A read when empty returns 0 and changes nothing.
- row_in passes through a 2-FF synchronizer before use.
- FSM:
  - IDLE: col_out=5'h1F. Moves to DRIVE with col=0 when enable=1.
  - DRIVE: col_out bit[col]=0. Settle counter runs 0..SETTLE_CYCLES-1, then SAMPLE.
  - SAMPLE: ROWS cycles; cycle r evaluates key (col,r).
  - NEXT: 1 cycle; col increments, 4 wraps to 0; back to DRIVE.
  - enable=0 in any state: IDLE next cycle.
- Per key (5×ROWS): stable bit (1=pressed, reset 0) and 4-bit counter.
  - Sample equal to stable: counter cleared.
  - Sample differs from stable: counter increments. When it reaches DEBOUNCE_SCANS, stable flips, counter clears and one event is pushed.
- At most one push per cycle; events enter in scan order.
- FIFO full on push:
  - Event is dropped and overflow is set.
  - Stable bit still flips.
  - Push and pop in the same cycle while full: both succeed, count is unchanged.
- Flush coinciding with push or pop: flush wins; FIFO empty, no event stored.
- Disable mid-scan: debounce counters clear; stable bits and FIFO contents are retained. Re-enable restarts at col 0.
- Unused readdata bits read 0; writes to RO registers are ignored.

## Timing
- Reset values:
  - col_out=5'h1F, readdata=0, irq=0.
  - FIFO empty, overflow=0, enable=0, mask=0.
  - All stable bits and counters 0, FSM in IDLE.
- Column period = SETTLE_CYCLES + ROWS + 1 clocks; full scan = 5× that.
- Enable write at cycle N: col_out=5'h1E at N+1.
- The push for key (c,r) occurs at SAMPLE cycle r of the DEBOUNCE_SCANS-th differing scan. Status count is updated the next cycle.
- Pop takes effect on the clock edge ending the read cycle; the next read returns the next entry.
- row_in changes no more than 2 clocks before a sample may be missed by that sample (synchronizer latency).

## Configuration
- KEYPAD_SCAN_IRQ_EN defined:
  - IRQ_MASK bit0 is RW, reset 0.
  - irq is registered: irq = mask & (count ≠ 0), updated one cycle after a count change.
- Undefined:
  - irq tied to 0.
  - IRQ_MASK reads 0 and ignores writes.
  - No mask register is synthesized.

## Test plan
Parameters for all scenarios: ROWS=4, SETTLE_CYCLES=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
- Reset: assert reset_n=0 mid-scan -> col_out=5'h1F, all registers 0, FSM IDLE. After release, read STATUS -> 0.
- Enable, hold row 2 low whenever col 3 is driven -> after the 2nd scan, EVENT reads 0x8000_0123. Release row 2 -> after 2 more scans, EVENT reads 0x8000_0023.
- Glitch: row 1 low for a single col-0 sample only -> no event; count stays 0.
- Overflow: press 5 keys with no reads -> count=4, bit16=1. Write 0x10000 to STATUS -> bit16=0. Reads return the first 4 events in scan order.
- Pop collides with push while full -> count stays 4, no overflow. Flush written the same cycle as a push -> count=0.
- With KEYPAD_SCAN_IRQ_EN: mask=1, one press -> irq=1 the cycle after count becomes 1, and irq=0 the cycle after the popping read. Without the macro: irq stays 0 and IRQ_MASK reads 0 after writing 1.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: Avalon-MM slave that scans a 5-column keypad and debounces
// every key. Press and release events are queued in a FIFO for the CPU.
// Latency: readdata is combinational (read latency 0). A key change is accepted
// and pushed at the SAMPLE cycle of the DEBOUNCE_SCANS-th differing scan.
// Backpressure: none towards the keypad. When the FIFO is full, the new event
// is dropped and the sticky overflow bit is set.
//
// Ports: clk, reset_n (async, active-low); Avalon slave address/chipselect/
// read_n/write_n/writedata/readdata; col_out (active-low column drive, one-cold
// while scanning); row_in (active-low row sense, asynchronous); irq.
// Optional feature macro: KEYPAD_SCAN_IRQ_EN (IRQ_MASK register plus registered irq).
//
// Registers: 0 EVENT (pops on read), 1 STATUS, 2 CONTROL, 3 IRQ_MASK.

module keypad_scan_ctrl #(
    parameter int ROWS           = 4,
    parameter int SETTLE_CYCLES  = 500,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            read_n,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [4:0]      col_out,
    input  logic [ROWS-1:0] row_in,
    output logic            irq
);

    localparam int NKEYS = 5 * ROWS;
    localparam int KW    = $clog2(NKEYS);
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_NEXT} state_t;

    state_t          state_q, state_d;
    logic [2:0]      col_q, col_d;
    logic [2:0]      row_q, row_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            enable_q, enable_d;
    logic            overflow_q;
    logic [ROWS-1:0] row_s1_q, row_s2_q;
    logic [NKEYS-1:0] stable_q;
    logic [3:0]      cnt_q [NKEYS];
    logic [6:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;

    // ---------------- bus decode ----------------
    logic rd_en, wr_en, pop, flush, fifo_full, fifo_empty;
    assign rd_en      = chipselect & ~read_n;
    assign wr_en      = chipselect & ~write_n;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = rd_en & (address == 2'd0) & ~fifo_empty;
    assign flush      = wr_en & (address == 2'd2) & writedata[1];
    assign enable_d   = (wr_en && address == 2'd2) ? writedata[0] : enable_q;

    logic unused_wdata;
    assign unused_wdata = ^{writedata[31:17], writedata[15:2]};

    // ---------------- scan FSM ----------------
    // Next-state looks at enable_d so an enable write is visible on col_out
    // in the very next cycle, and a disable write returns to IDLE just as fast.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        settle_d = settle_q;
        case (state_q)
            S_IDLE: begin
                col_d    = 3'd0;
                row_d    = 3'd0;
                settle_d = '0;
                if (enable_d) state_d = S_DRIVE;
            end
            S_DRIVE: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    settle_d = '0;
                    row_d    = 3'd0;
                    state_d  = S_SAMPLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            S_SAMPLE: begin
                if (row_q == 3'(ROWS - 1)) state_d = S_NEXT;
                else                       row_d   = row_q + 3'd1;
            end
            S_NEXT: begin
                col_d    = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
                settle_d = '0;
                state_d  = S_DRIVE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!enable_d) begin
            state_d  = S_IDLE;
            col_d    = 3'd0;
            row_d    = 3'd0;
            settle_d = '0;
        end
    end

    assign col_out = (state_q == S_IDLE) ? 5'h1F : ~(5'b00001 << col_q);

    // ---------------- debounce ----------------
    logic [7:0]    row_pad;
    logic [KW-1:0] key_idx;
    logic          sample_pressed, cur_stable, push_req;
    logic [3:0]    cur_cnt, key_cnt_d;

    always_comb begin
        row_pad = '1;
        row_pad[ROWS-1:0] = row_s2_q;
    end

    assign key_idx        = KW'(col_q) * KW'(ROWS) + KW'(row_q);
    assign sample_pressed = ~row_pad[row_q];
    assign cur_stable     = stable_q[key_idx];
    assign cur_cnt        = cnt_q[key_idx];

    always_comb begin
        push_req  = 1'b0;
        key_cnt_d = cur_cnt;
        if (state_q == S_SAMPLE) begin
            if (sample_pressed == cur_stable) begin
                key_cnt_d = 4'd0;
            end else if (cur_cnt == 4'(DEBOUNCE_SCANS - 1)) begin
                key_cnt_d = 4'd0;
                push_req  = 1'b1;
            end else begin
                key_cnt_d = cur_cnt + 4'd1;
            end
        end
    end

    // ---------------- FIFO control ----------------
    // A push into a full FIFO still succeeds when the head is popped in the
    // same cycle; flush overrides both.
    logic do_push, do_pop, ovf_set;
    assign do_push = push_req & (~fifo_full | pop) & ~flush;
    assign do_pop  = pop & ~flush;
    assign ovf_set = push_req & fifo_full & ~pop & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            col_q      <= 3'd0;
            row_q      <= 3'd0;
            settle_q   <= '0;
            enable_q   <= 1'b0;
            overflow_q <= 1'b0;
            row_s1_q   <= '1;
            row_s2_q   <= '1;
            stable_q   <= '0;
            for (int k = 0; k < NKEYS; k++) cnt_q[k] <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            enable_q <= enable_d;
            row_s1_q <= row_in;
            row_s2_q <= row_s1_q;

            // Disabling drops partial debounce progress; stable bits persist.
            if (!enable_q) begin
                for (int k = 0; k < NKEYS; k++) cnt_q[k] <= 4'd0;
            end else if (state_q == S_SAMPLE) begin
                cnt_q[key_idx] <= key_cnt_d;
                if (push_req) stable_q[key_idx] <= ~cur_stable;
            end

            if (ovf_set)
                overflow_q <= 1'b1;
            else if (wr_en && address == 2'd1 && writedata[16])
                overflow_q <= 1'b0;

            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                if (do_push && !do_pop)      count_q <= count_q + CW'(1);
                else if (!do_push && do_pop) count_q <= count_q - CW'(1);
            end
        end
    end

    // Event payload: {press, row[2:0], col[2:0]}.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {~cur_stable, row_q, col_q};
    end

`ifdef KEYPAD_SCAN_IRQ_EN
    logic mask_q, irq_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && address == 2'd3) mask_q <= writedata[0];
            irq_q <= mask_q & ~fifo_empty;
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ---------------- read mux ----------------
    logic [6:0] head;
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        readdata = 32'd0;
        if (rd_en) begin
            case (address)
                2'd0: if (!fifo_empty)
                          readdata = {1'b1, 22'd0, head[6], 1'b0, head[5:3], 1'b0, head[2:0]};
                2'd1: begin
                    readdata[CW-1:0] = count_q;
                    readdata[16]     = overflow_q;
                    readdata[24]     = enable_q;
                end
                2'd2: readdata[0] = enable_q;
`ifdef KEYPAD_SCAN_IRQ_EN
                2'd3: readdata[0] = mask_q;
`endif
                default: readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl with a behavioural keypad matrix
// and a scoreboard of expected EVENT words.
module tb_keypad_scan_ctrl;

`ifdef KEYPAD_SCAN_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata, readdata;
    logic [4:0]  col_out;
    logic [3:0]  row_in;
    logic        irq;

    logic [19:0] keys;          // key (c,r) at index c*4+r, 1 = pressed
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    keypad_scan_ctrl #(
        .ROWS(4), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .col_out(col_out), .row_in(row_in), .irq(irq)
    );

    always #5 clk = ~clk;

    // Passive keypad: a pressed key shorts its row to a driven (low) column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
    end

    function automatic logic [31:0] ev(input logic p, input int r, input int c);
        return 32'h8000_0000 | (32'(p) << 8) | (32'(r) << 4) | 32'(c);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks: called just after a negedge, hold the access for one cycle.
    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        #1 d = readdata;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check_val(tag, d, exp);
    endtask

    task automatic check_event(input string tag);
        logic [31:0] d, e;
        bus_read(2'd0, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        check_val(tag, d, e);
    endtask

    task automatic wait_col(input logic [4:0] v);
        int n = 0;
        while (col_out !== v && n < 200) begin @(negedge clk); n++; end
        if (col_out !== v) check_val("wait_col", 32'(col_out), 32'(v));
    endtask

    task automatic wait_col_not(input logic [4:0] v);
        int n = 0;
        while (col_out === v && n < 200) begin @(negedge clk); n++; end
        if (col_out === v) check_val("wait_col_not", 32'(col_out), ~32'(v));
    endtask

    // Leaves the bench at the negedge of the first cycle column 0 is driven.
    task automatic wait_scan_start();
        wait_col_not(5'h1E);
        wait_col(5'h1E);
    endtask

    initial begin
        logic [31:0] d;
        int n;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0;
        read_n = 1'b1; write_n = 1'b1; writedata = 32'd0; keys = '0;

        // Reset state
        #3;
        check_val("rst_col", 32'(col_out), 32'h1F);
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_rdata", readdata, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Reset asserted mid-scan
        bus_write(2'd2, 32'd1);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_val("midrst_col", 32'(col_out), 32'h1F);
        @(negedge clk);
        check_reg("midrst_ctrl", 2'd2, 32'd0);
        reset_n = 1'b1;
        check_reg("post_rst_status", 2'd1, 32'd0);
        check_reg("post_rst_ctrl", 2'd2, 32'd0);
        check_reg("post_rst_event", 2'd0, 32'd0);
        check_reg("post_rst_mask", 2'd3, 32'd0);

        // Enable: column 0 driven next cycle, held for one column period
        bus_write(2'd2, 32'd1);
        check_val("en_col0", 32'(col_out), 32'h1E);
        n = 0;
        while (col_out === 5'h1E && n < 100) begin n++; @(negedge clk); end
        check_val("col_period", 32'(n), 32'd9);
        check_val("col1", 32'(col_out), 32'h1D);

        // Press key (3,2) then release
        wait_scan_start();
        keys[3*4+2] = 1'b1; exp_q.push_back(ev(1'b1, 2, 3));
        wait_scan_start(); wait_scan_start();
        check_reg("press_status", 2'd1, 32'h0100_0001);
        check_event("press_event");
        check_event("empty_event");
        wait_scan_start();
        keys[3*4+2] = 1'b0; exp_q.push_back(ev(1'b0, 2, 3));
        wait_scan_start(); wait_scan_start();
        check_event("release_event");

        // Glitch: key (0,1) seen by a single column-0 sample
        wait_scan_start();
        keys[0*4+1] = 1'b1;
        wait_col(5'h1D);
        keys[0*4+1] = 1'b0;
        wait_scan_start(); wait_scan_start(); wait_scan_start();
        check_reg("glitch_status", 2'd1, 32'h0100_0000);

        // Overflow: five presses, only the first four in scan order are kept
        wait_scan_start();
        keys[0*4+0] = 1'b1; keys[1*4+1] = 1'b1; keys[2*4+2] = 1'b1;
        keys[3*4+3] = 1'b1; keys[4*4+0] = 1'b1;
        exp_q.push_back(ev(1'b1, 0, 0)); exp_q.push_back(ev(1'b1, 1, 1));
        exp_q.push_back(ev(1'b1, 2, 2)); exp_q.push_back(ev(1'b1, 3, 3));
        wait_scan_start(); wait_scan_start();
        check_reg("ovf_status", 2'd1, 32'h0101_0004);
        bus_write(2'd1, 32'h0001_0000);
        check_reg("ovf_clr_status", 2'd1, 32'h0100_0004);
        for (int i = 0; i < 4; i++) check_event("ovf_event");
        check_event("ovf_empty");

        // Pop and push in the same cycle while full
        wait_scan_start();
        keys = '0;
        exp_q.push_back(ev(1'b0, 0, 0)); exp_q.push_back(ev(1'b0, 1, 1));
        exp_q.push_back(ev(1'b0, 2, 2)); exp_q.push_back(ev(1'b0, 3, 3));
        exp_q.push_back(ev(1'b0, 0, 4));
        wait_scan_start();
        wait_col(5'h0F);
        repeat (4) @(negedge clk);              // SAMPLE cycle of key (4,0)
        check_event("collide_event");
        check_reg("collide_status", 2'd1, 32'h0100_0004);
        for (int i = 0; i < 4; i++) check_event("collide_drain");
        check_event("collide_empty");

        // Flush in the same cycle as a push
        wait_scan_start();
        keys[2*4+1] = 1'b1;
        wait_scan_start();
        wait_col(5'h1B);
        repeat (5) @(negedge clk);              // SAMPLE cycle of key (2,1)
        bus_write(2'd2, 32'd3);
        check_reg("flush_status", 2'd1, 32'h0100_0000);
        check_event("flush_empty");

        // Interrupt on release of (2,1)
        bus_write(2'd3, 32'd1);
        check_reg("mask_rd", 2'd3, 32'(IRQ_ON));
        wait_scan_start();
        keys[2*4+1] = 1'b0; exp_q.push_back(ev(1'b0, 1, 2));
        wait_scan_start();
        wait_col(5'h1B);
        repeat (6) @(negedge clk);              // count becomes 1 this cycle
        check_val("irq_pre", 32'(irq), 32'd0);
        @(negedge clk);
        check_val("irq_set", 32'(irq), 32'(IRQ_ON));
        check_event("irq_event");
        @(negedge clk);
        check_val("irq_clr", 32'(irq), 32'd0);

        // Disable mid-scan clears partial debounce progress
        wait_scan_start();
        keys[4*4+3] = 1'b1; exp_q.push_back(ev(1'b1, 3, 4));
        wait_col(5'h0F); wait_col_not(5'h0F);   // one differing sample taken
        bus_write(2'd2, 32'd0);
        check_val("dis_col", 32'(col_out), 32'h1F);
        bus_write(2'd2, 32'd1);
        check_val("reen_col", 32'(col_out), 32'h1E);
        wait_col(5'h0F); wait_col_not(5'h0F);
        check_reg("dis_status", 2'd1, 32'h0100_0000);
        wait_col(5'h0F); wait_col_not(5'h0F);
        check_reg("reen_status", 2'd1, 32'h0100_0001);
        check_event("reen_event");
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
